// File: rtl/mem_bridge_pkg.sv
// mem_bridge_pkg: shared constants and types for the MEM-stage system bridge.
//   EXC_ADEL / EXC_ADES : address-error exception codes (load / store).
//   SIZE_*              : req_size encodings.
//   ST_*                : bridge FSM state encodings.
//   acc_t               : the access that is latched when a request is issued.
package mem_bridge_pkg;

   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } acc_t;

   // Address errors are reported as AdES for stores and AdEL for loads.
   function automatic logic [4:0] addr_exc(input logic we);
      return we ? EXC_ADES : EXC_ADEL;
   endfunction

endpackage

// File: rtl/mem_bridge_decode.sv
// mem_bridge_decode: combinational address decode and access-rule checks.
//   addr, size, we, ovf : the MEM-stage request.
//   sel                 : one-hot window hit (lowest index wins on overlap).
//   idx                 : binary index of the selected window.
//   err                 : any address-rule violation (overflow, misalignment,
//                         no window hit, store to read-only, non-word access
//                         to a word-only slave).
module mem_bridge_decode
   import mem_bridge_pkg::*;
#(
   parameter int                     NUM_SLV       = 3,
   parameter int                     IDX_W         = 2,
   parameter logic [NUM_SLV*32-1:0]  SLV_BASE      = {32'h7F10, 32'h7F00, 32'h0},
   parameter logic [NUM_SLV*32-1:0]  SLV_LAST      = {32'h7F1B, 32'h7F0B, 32'h2FFF},
   parameter logic [NUM_SLV-1:0]     SLV_RO        = '0,
   parameter logic [NUM_SLV-1:0]     SLV_WORD_ONLY = 3'b110
)(
   input  logic [31:0]        addr,
   input  logic [1:0]         size,
   input  logic               we,
   input  logic               ovf,
   output logic [NUM_SLV-1:0] sel,
   output logic [IDX_W-1:0]   idx,
   output logic               err
);

   logic [NUM_SLV-1:0] win;
   logic               hit;
   logic               misalign;
   logic               ro_viol;
   logic               wo_viol;

   for (genvar i = 0; i < NUM_SLV; i++) begin : g_win
      assign win[i] = (addr >= SLV_BASE[i*32 +: 32]) && (addr <= SLV_LAST[i*32 +: 32]);
   end

   // Scan from the top so the lowest matching index is the one left standing.
   always_comb begin
      hit = 1'b0;
      idx = '0;
      sel = '0;
      for (int i = NUM_SLV - 1; i >= 0; i--) begin
         if (win[i]) begin
            hit    = 1'b1;
            idx    = IDX_W'(i);
            sel    = '0;
            sel[i] = 1'b1;
         end
      end
   end

   assign misalign = ((size == SIZE_HALF) && addr[0]) ||
                     ((size == SIZE_WORD) && (addr[1:0] != 2'b00));
   assign ro_viol  = hit && we && |(sel & SLV_RO);
   assign wo_viol  = hit && (size != SIZE_WORD) && |(sel & SLV_WORD_ONLY);

   // Every rule maps to the same AdEL/AdES code, so the ordering among them
   // does not change the result and a plain OR is enough.
   assign err = ovf | misalign | ~hit | ro_viol | wo_viol;

endmodule

// File: rtl/mem_bridge.sv
// mem_bridge: MEM-stage bridge between the pipeline and NUM_SLV memory-mapped
// slaves. Decodes and checks each load/store, runs a sel/ready handshake with
// the selected slave, stalls the pipeline during wait states and turns a hung
// slave into an address exception after TIMEOUT busy cycles.
//   clk, reset          : clock, asynchronous active-high reset.
//   flush               : kill the instruction currently in MEM.
//   req_*               : load/store request from MEM; exc_in from earlier stages.
//   stall               : freeze IF..MEM.
//   rdata, resp_valid   : raw read word and completion strobe.
//   exc_out             : resulting exception code.
//   slv_*               : slave-side select/strobe/address/data and per-slave
//                         read data and ready.
// Optional build macro MEM_BRIDGE_ERRLOG_EN adds err_addr / err_cnt, which
// record the last faulting address and a saturating count of faults raised
// by this block.
module mem_bridge
   import mem_bridge_pkg::*;
#(
   parameter int                     NUM_SLV       = 3,
   parameter logic [NUM_SLV*32-1:0]  SLV_BASE      = {32'h7F10, 32'h7F00, 32'h0},
   parameter logic [NUM_SLV*32-1:0]  SLV_LAST      = {32'h7F1B, 32'h7F0B, 32'h2FFF},
   parameter logic [NUM_SLV-1:0]     SLV_RO        = '0,
   parameter logic [NUM_SLV-1:0]     SLV_WORD_ONLY = 3'b110,
   parameter int                     TIMEOUT       = 15
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  req_valid,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic [31:0]           req_addr,
   input  logic [3:0]            req_be,
   input  logic [31:0]           req_wdata,
   input  logic                  req_ovf,
   input  logic [4:0]            exc_in,
   output logic                  stall,
   output logic [31:0]           rdata,
   output logic                  resp_valid,
   output logic [4:0]            exc_out,
   output logic [NUM_SLV-1:0]    slv_sel,
   output logic                  slv_we,
   output logic [31:0]           slv_addr,
   output logic [3:0]            slv_be,
   output logic [31:0]           slv_wdata,
   input  logic [NUM_SLV*32-1:0] slv_rdata,
   input  logic [NUM_SLV-1:0]    slv_ready
`ifdef MEM_BRIDGE_ERRLOG_EN
   ,
   output logic [31:0]           err_addr,
   output logic [7:0]            err_cnt
`endif
);

   localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [1:0]         state;
   acc_t               acc_q;
   logic [IDX_W-1:0]   idx_q;
   logic [NUM_SLV-1:0] sel_q;
   logic [CNT_W-1:0]   cnt;
   logic [4:0]         exc_q;
   logic               flush_q;

   logic [NUM_SLV-1:0] dec_sel;
   logic [IDX_W-1:0]   dec_idx;
   logic               dec_err;

   logic [4:0]         req_exc;
   logic               issue;
   logic               busy;
   logic               rdy;
   logic               tmo;
   logic               kill;

   mem_bridge_decode #(
      .NUM_SLV       (NUM_SLV),
      .IDX_W         (IDX_W),
      .SLV_BASE      (SLV_BASE),
      .SLV_LAST      (SLV_LAST),
      .SLV_RO        (SLV_RO),
      .SLV_WORD_ONLY (SLV_WORD_ONLY)
   ) u_decode (
      .addr (req_addr),
      .size (req_size),
      .we   (req_we),
      .ovf  (req_ovf),
      .sel  (dec_sel),
      .idx  (dec_idx),
      .err  (dec_err)
   );

   // An upstream exception always takes precedence over our own checks.
   always_comb begin
      req_exc = 5'd0;
      if (exc_in != 5'd0)
         req_exc = exc_in;
      else if (req_valid && dec_err)
         req_exc = addr_exc(req_we);
   end

   assign issue = (state == ST_IDLE) && req_valid && !flush && (req_exc == 5'd0);
   assign busy  = (state == ST_BUSY);
   assign rdy   = |(slv_ready & sel_q);
   assign tmo   = (cnt == CNT_W'(TIMEOUT - 1));
   // A flush seen while busy cannot undo a slave write, so it only hides the
   // completion from the pipeline.
   assign kill  = flush_q | flush;

   always_comb begin
      stall      = 1'b0;
      resp_valid = 1'b0;
      exc_out    = 5'd0;
      case (state)
         ST_IDLE: begin
            stall   = issue;
            exc_out = req_exc;
         end
         ST_BUSY: stall = 1'b1;
         ST_RESP: begin
            resp_valid = !kill;
            exc_out    = kill ? 5'd0 : exc_q;
         end
         default: ;
      endcase
      // Combinational outputs are held quiet while reset is asserted.
      if (reset) begin
         stall      = 1'b0;
         resp_valid = 1'b0;
         exc_out    = 5'd0;
      end
   end

   assign slv_sel   = busy ? sel_q       : '0;
   assign slv_we    = busy & acc_q.we;
   assign slv_addr  = busy ? acc_q.addr  : 32'd0;
   assign slv_be    = busy ? acc_q.be    : 4'd0;
   assign slv_wdata = busy ? acc_q.wdata : 32'd0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         acc_q   <= '0;
         idx_q   <= '0;
         sel_q   <= '0;
         cnt     <= '0;
         exc_q   <= 5'd0;
         flush_q <= 1'b0;
         rdata   <= 32'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (issue) begin
                  acc_q   <= '{we: req_we, addr: req_addr, be: req_be, wdata: req_wdata};
                  idx_q   <= dec_idx;
                  sel_q   <= dec_sel;
                  cnt     <= '0;
                  exc_q   <= 5'd0;
                  flush_q <= 1'b0;
                  state   <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (flush)
                  flush_q <= 1'b1;
               // Ready is checked first so a last-cycle completion is not lost.
               if (rdy) begin
                  rdata <= slv_rdata[idx_q*32 +: 32];
                  exc_q <= 5'd0;
                  state <= ST_RESP;
               end else if (tmo) begin
                  rdata <= 32'd0;
                  exc_q <= addr_exc(acc_q.we);
                  state <= ST_RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_RESP: begin
               flush_q <= 1'b0;
               state   <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef MEM_BRIDGE_ERRLOG_EN
   logic        log_evt;
   logic [31:0] log_addr;

   // Faults raised here: a rule violation on an IDLE request without an
   // upstream exception, or a slave timeout.
   assign log_evt  = ((state == ST_IDLE) && req_valid && (exc_in == 5'd0) && dec_err) ||
                     (busy && !rdy && tmo);
   assign log_addr = busy ? acc_q.addr : req_addr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_addr <= 32'd0;
         err_cnt  <= 8'd0;
      end else if (log_evt) begin
         err_addr <= log_addr;
         if (err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge: directed self-checking bench for mem_bridge with the default
// window map (DM 0x0-0x2FFF, timer 0x7F00-0x7F0B, slave 2 0x7F10-0x7F1B).
module tb_mem_bridge;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        req_valid;
   logic        req_we;
   logic [1:0]  req_size;
   logic [31:0] req_addr;
   logic [3:0]  req_be;
   logic [31:0] req_wdata;
   logic        req_ovf;
   logic [4:0]  exc_in;
   logic        stall;
   logic [31:0] rdata;
   logic        resp_valid;
   logic [4:0]  exc_out;
   logic [2:0]  slv_sel;
   logic        slv_we;
   logic [31:0] slv_addr;
   logic [3:0]  slv_be;
   logic [31:0] slv_wdata;
   logic [95:0] slv_rdata;
   logic [2:0]  slv_ready;
`ifdef MEM_BRIDGE_ERRLOG_EN
   logic [31:0] err_addr;
   logic [7:0]  err_cnt;
`endif

   int n_chk;
   int n_err;
   int we_rises;
   logic prev_we;

   mem_bridge dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .req_valid  (req_valid),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_addr   (req_addr),
      .req_be     (req_be),
      .req_wdata  (req_wdata),
      .req_ovf    (req_ovf),
      .exc_in     (exc_in),
      .stall      (stall),
      .rdata      (rdata),
      .resp_valid (resp_valid),
      .exc_out    (exc_out),
      .slv_sel    (slv_sel),
      .slv_we     (slv_we),
      .slv_addr   (slv_addr),
      .slv_be     (slv_be),
      .slv_wdata  (slv_wdata),
      .slv_rdata  (slv_rdata),
      .slv_ready  (slv_ready)
`ifdef MEM_BRIDGE_ERRLOG_EN
      ,
      .err_addr   (err_addr),
      .err_cnt    (err_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic req(input logic we, input logic [1:0] size, input logic [31:0] addr);
      req_valid = 1'b1;
      req_we    = we;
      req_size  = size;
      req_addr  = addr;
   endtask

   task automatic idle_in();
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_size  = 2'd0;
      req_addr  = 32'd0;
      req_ovf   = 1'b0;
      exc_in    = 5'd0;
      flush     = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not reach its end");
      $fatal(1);
   end

   initial begin
      n_chk = 0;
      n_err = 0;
      reset = 1'b1;
      idle_in();
      req_be    = 4'h0;
      req_wdata = 32'd0;
      slv_ready = 3'b000;
      slv_rdata = {32'h5A5A5A5A, 32'hCAFEF00D, 32'hDEADBEEF};

      // Reset state
      repeat (2) step();
      smp();
      chk("rst stall",   32'(stall), 32'd0);
      chk("rst resp",    32'(resp_valid), 32'd0);
      chk("rst sel",     32'(slv_sel), 32'd0);
      chk("rst we",      32'(slv_we), 32'd0);
      chk("rst addr",    slv_addr, 32'd0);
      chk("rst rdata",   rdata, 32'd0);
      chk("rst exc",     32'(exc_out), 32'd0);
      step();
      reset = 1'b0;

      // Load word from DM, ready on the first busy cycle
      step();
      req(1'b0, 2'd2, 32'h0000_0100);
      slv_ready = 3'b001;
      smp();
      chk("ld idle stall", 32'(stall), 32'd1);
      chk("ld idle exc",   32'(exc_out), 32'd0);
      chk("ld idle sel",   32'(slv_sel), 32'd0);
      step();
      smp();
      chk("ld busy stall", 32'(stall), 32'd1);
      chk("ld busy sel",   32'(slv_sel), 32'd1);
      chk("ld busy we",    32'(slv_we), 32'd0);
      chk("ld busy addr",  slv_addr, 32'h0000_0100);
      step();
      smp();
      chk("ld resp stall", 32'(stall), 32'd0);
      chk("ld resp valid", 32'(resp_valid), 32'd1);
      chk("ld resp rdata", rdata, 32'hDEADBEEF);
      chk("ld resp exc",   32'(exc_out), 32'd0);
      chk("ld resp nosel", 32'(slv_sel), 32'd0);
      step();
      idle_in();

      // Rule checks: no access, exception in the same cycle
      step();
      req(1'b1, 2'd1, 32'h0000_7F02);
      smp();
      chk("sh timer sel",   32'(slv_sel), 32'd0);
      chk("sh timer exc",   32'(exc_out), 32'd5);
      chk("sh timer stall", 32'(stall), 32'd0);
      step();
      req(1'b0, 2'd2, 32'h0000_3000);
      smp();
      chk("nohit exc",   32'(exc_out), 32'd4);
      chk("nohit stall", 32'(stall), 32'd0);
      step();
      req(1'b0, 2'd2, 32'h0000_7F0C);
      smp();
      chk("past timer exc", 32'(exc_out), 32'd4);
      step();
      req(1'b0, 2'd2, 32'h0000_0102);
      smp();
      chk("misalign exc", 32'(exc_out), 32'd4);
      step();
      req(1'b1, 2'd0, 32'h0000_7F10);
      smp();
      chk("sb s2 exc", 32'(exc_out), 32'd5);
      step();
      req(1'b0, 2'd2, 32'h0000_0100);
      req_ovf = 1'b1;
      smp();
      chk("ovf exc",   32'(exc_out), 32'd4);
      chk("ovf stall", 32'(stall), 32'd0);
      step();
      req_ovf = 1'b0;
      req(1'b0, 2'd2, 32'h0000_3001);
      exc_in = 5'd10;
      smp();
      chk("exc pass",       32'(exc_out), 32'd10);
      chk("exc pass stall", 32'(stall), 32'd0);
      step();
      idle_in();
      slv_ready = 3'b000;

      // Store word to slave 2 that never answers: 15 busy cycles then abort
      step();
      req(1'b1, 2'd2, 32'h0000_7F10);
      req_be    = 4'hF;
      req_wdata = 32'h11223344;
      smp();
      chk("to idle stall", 32'(stall), 32'd1);
      for (int k = 0; k < 15; k++) begin
         step();
         smp();
         chk("to busy stall", 32'(stall), 32'd1);
         chk("to busy sel",   32'(slv_sel), 32'd4);
      end
      chk("to busy we",    32'(slv_we), 32'd1);
      chk("to busy wdata", slv_wdata, 32'h11223344);
      step();
      smp();
      chk("to resp stall", 32'(stall), 32'd0);
      chk("to resp valid", 32'(resp_valid), 32'd1);
      chk("to resp exc",   32'(exc_out), 32'd5);
      chk("to resp rdata", rdata, 32'd0);
      step();
      idle_in();

      // Store word to the timer, ready on the third busy cycle, flush in busy
      step();
      req(1'b1, 2'd2, 32'h0000_7F04);
      req_be    = 4'hF;
      req_wdata = 32'h0BADF00D;
      smp();
      chk("fl idle stall", 32'(stall), 32'd1);
      we_rises = 0;
      prev_we  = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         flush     = (c == 0);
         slv_ready = (c == 2) ? 3'b010 : 3'b000;
         smp();
         chk("fl busy sel", 32'(slv_sel), 32'd2);
         if (slv_we && !prev_we)
            we_rises++;
         prev_we = slv_we;
      end
      chk("fl busy addr", slv_addr, 32'h0000_7F04);
      chk("fl busy be",   32'(slv_be), 32'hF);
      step();
      flush     = 1'b0;
      slv_ready = 3'b000;
      smp();
      chk("fl we once",    32'(we_rises), 32'd1);
      chk("fl resp valid", 32'(resp_valid), 32'd0);
      chk("fl resp exc",   32'(exc_out), 32'd0);
      chk("fl resp stall", 32'(stall), 32'd0);
      chk("fl resp rdata", rdata, 32'hCAFEF00D);
      step();
      idle_in();

      // Reset in the middle of a busy access
      step();
      req(1'b1, 2'd2, 32'h0000_7F10);
      step();
      smp();
      chk("mr busy sel", 32'(slv_sel), 32'd4);
      #2;
      reset = 1'b1;
      #1;
      chk("mr stall", 32'(stall), 32'd0);
      chk("mr sel",   32'(slv_sel), 32'd0);
      chk("mr we",    32'(slv_we), 32'd0);
      chk("mr addr",  slv_addr, 32'd0);
      chk("mr rdata", rdata, 32'd0);
      chk("mr resp",  32'(resp_valid), 32'd0);
      chk("mr exc",   32'(exc_out), 32'd0);
      step();
      reset = 1'b0;
      idle_in();

`ifdef MEM_BRIDGE_ERRLOG_EN
      smp();
      chk("log rst cnt",  32'(err_cnt), 32'd0);
      chk("log rst addr", err_addr, 32'd0);
      for (int i = 0; i < 260; i++) begin
         step();
         req(1'b0, 2'd2, 32'h0000_1000 + 32'(i) * 32'd4 + 32'd2);
         if (i == 1) begin
            smp();
            chk("log cnt one", 32'(err_cnt), 32'd1);
         end
      end
      step();
      idle_in();
      smp();
      chk("log cnt sat", 32'(err_cnt), 32'd255);
      chk("log addr",    err_addr, 32'h0000_1000 + 32'd259 * 32'd4 + 32'd2);
`endif

      step();
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
